// File: rtl/h264_dc_hadamard.sv
//----------------------------------------------------------------------------
// Module   : h264_dc_hadamard
// Purpose  : Forward DC Hadamard transform for the H.264 encoder. Accepts a
//            2x2 chroma DC block (4 coeffs) or a 4x4 Intra16x16 luma DC block
//            (16 coeffs) serially in raster order, transforms it in place in a
//            single block buffer, and emits the saturated results serially.
// Ports    : CLK     - clock, rising edge
//            RESET   - asynchronous active-high reset
//            MODE    - 0 = 2x2 chroma, 1 = 4x4 luma (sampled with first coeff)
//            ENABLE  - XXIN valid; transfer = ENABLE & READYI
//            XXIN    - signed input coefficient
//            READYI  - block can accept a coefficient
//            VALID   - YYOUT holds a result coefficient
//            YYOUT   - saturated signed result coefficient
//            YYLAST  - final coefficient of the block
//            READYO  - downstream accepts; transfer = VALID & READYO
// Revision : 1.0 - initial release
//----------------------------------------------------------------------------
`default_nettype none

module h264_dc_hadamard #(
  parameter int IN_WIDTH  = 16,
  parameter int OUT_WIDTH = 16,  // must not exceed IN_WIDTH+4
  parameter bit LUMA_EN   = 1'b1
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic                 MODE,
  input  logic                 ENABLE,
  input  logic [IN_WIDTH-1:0]  XXIN,
  output logic                 READYI,
  output logic                 VALID,
  output logic [OUT_WIDTH-1:0] YYOUT,
  output logic                 YYLAST,
  input  logic                 READYO
);

  // Four extra bits hold the full 16-point sum without overflow.
  localparam int AW = IN_WIDTH + 4;

  localparam logic [1:0] S_LOAD = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_OUT  = 2'd2;

  localparam longint C_MAX = (64'sd1 <<< (OUT_WIDTH - 1)) - 64'sd1;
  localparam longint C_MIN = -(64'sd1 <<< (OUT_WIDTH - 1));

  logic [1:0] state_q, state_d;
  logic [3:0] cnt_q;    // input coefficient index
  logic [2:0] ccnt_q;   // calculation step
  logic [3:0] ocnt_q;   // output coefficient index
  logic       mode_q;   // 1 = luma block in flight

  logic signed [AW-1:0] buf_q [16];
  logic signed [AW-1:0] buf_d [16];

  logic w_mode_in, w_mode_eff;
  logic w_in_xfer, w_load_done, w_calc_done, w_out_xfer, w_out_last;

  // Without the luma path MODE is forced low, so all luma logic is constant.
  assign w_mode_in   = LUMA_EN & MODE;
  // The block size is decided by MODE on the first transfer, by the latch after.
  assign w_mode_eff  = (cnt_q == 4'd0) ? w_mode_in : mode_q;
  assign w_in_xfer   = (state_q == S_LOAD) && ENABLE;
  assign w_load_done = w_in_xfer && (cnt_q == (w_mode_eff ? 4'd15 : 4'd3));
  assign w_calc_done = (state_q == S_CALC) && (ccnt_q == (mode_q ? 3'd7 : 3'd1));
  assign w_out_last  = (ocnt_q == (mode_q ? 4'd15 : 4'd3));
  assign w_out_xfer  = (state_q == S_OUT) && READYO;

  //--------------------------------------------------------------------------
  // FSM: state register
  //--------------------------------------------------------------------------
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) state_q <= S_LOAD;
    else       state_q <= state_d;
  end

  //--------------------------------------------------------------------------
  // FSM: next state
  //--------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_LOAD:  if (w_load_done) state_d = S_CALC;
      S_CALC:  if (w_calc_done) state_d = S_OUT;
      S_OUT:   if (w_out_xfer && w_out_last) state_d = S_LOAD;
      default: state_d = S_LOAD;
    endcase
  end

  //--------------------------------------------------------------------------
  // Result selection, luma halving and saturation
  //--------------------------------------------------------------------------
  logic signed [AW-1:0]        w_sel, w_scaled;
  logic signed [OUT_WIDTH-1:0] w_sat;

  always_comb begin
    w_sel    = buf_q[ocnt_q];
    w_scaled = mode_q ? (w_sel >>> 1) : w_sel;
    if (longint'(w_scaled) > C_MAX)      w_sat = C_MAX[OUT_WIDTH-1:0];
    else if (longint'(w_scaled) < C_MIN) w_sat = C_MIN[OUT_WIDTH-1:0];
    else                                 w_sat = w_scaled[OUT_WIDTH-1:0];
  end

  //--------------------------------------------------------------------------
  // FSM: outputs
  //--------------------------------------------------------------------------
  always_comb begin
    READYI = 1'b0;
    VALID  = 1'b0;
    YYLAST = 1'b0;
    YYOUT  = '0;
    case (state_q)
      S_LOAD: READYI = 1'b1;
      S_OUT: begin
        VALID  = 1'b1;
        YYLAST = w_out_last;
        YYOUT  = w_sat;
      end
      default: ;
    endcase
  end

  //--------------------------------------------------------------------------
  // Butterflies. Luma steps 0..3 transform row ccnt, steps 4..7 column
  // ccnt[1:0]. Chroma step 0 pairs (0,1)/(2,3), step 1 pairs (0,2)/(1,3).
  //--------------------------------------------------------------------------
  logic        [3:0]    w_idx [4];
  logic signed [AW-1:0] w_x   [4];
  logic signed [AW-1:0] w_y   [4];
  logic        [3:0]    w_ca1, w_cb0;

  always_comb begin
    for (int k = 0; k < 4; k++) begin
      if (ccnt_q[2]) w_idx[k] = {2'(k), ccnt_q[1:0]};
      else           w_idx[k] = {ccnt_q[1:0], 2'(k)};
      w_x[k] = buf_q[w_idx[k]];
    end
    w_y[0] = w_x[0] + w_x[1] + w_x[2] + w_x[3];
    w_y[1] = w_x[0] + w_x[1] - w_x[2] - w_x[3];
    w_y[2] = w_x[0] - w_x[1] - w_x[2] + w_x[3];
    w_y[3] = w_x[0] - w_x[1] + w_x[2] - w_x[3];
    w_ca1  = ccnt_q[0] ? 4'd2 : 4'd1;
    w_cb0  = ccnt_q[0] ? 4'd1 : 4'd2;
  end

  always_comb begin
    buf_d = buf_q;
    case (state_q)
      S_LOAD: if (w_in_xfer) buf_d[cnt_q] = {{4{XXIN[IN_WIDTH-1]}}, XXIN};
      S_CALC: begin
        if (mode_q) begin
          for (int k = 0; k < 4; k++) buf_d[w_idx[k]] = w_y[k];
        end else begin
          buf_d[0]     = buf_q[0] + buf_q[w_ca1];
          buf_d[w_ca1] = buf_q[0] - buf_q[w_ca1];
          buf_d[w_cb0] = buf_q[w_cb0] + buf_q[3];
          buf_d[3]     = buf_q[w_cb0] - buf_q[3];
        end
      end
      default: ;
    endcase
  end

  //--------------------------------------------------------------------------
  // Counters, mode latch and block buffer
  //--------------------------------------------------------------------------
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      cnt_q  <= '0;
      ccnt_q <= '0;
      ocnt_q <= '0;
      mode_q <= 1'b0;
      for (int i = 0; i < 16; i++) buf_q[i] <= '0;
    end else begin
      buf_q <= buf_d;
      case (state_q)
        S_LOAD: begin
          ccnt_q <= '0;
          if (w_in_xfer) begin
            if (cnt_q == 4'd0) mode_q <= w_mode_in;
            cnt_q <= w_load_done ? 4'd0 : cnt_q + 4'd1;
          end
        end
        S_CALC: begin
          ocnt_q <= '0;
          ccnt_q <= w_calc_done ? 3'd0 : ccnt_q + 3'd1;
        end
        S_OUT: begin
          if (w_out_xfer) ocnt_q <= w_out_last ? 4'd0 : ocnt_q + 4'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_h264_dc_hadamard.sv
//----------------------------------------------------------------------------
// Module   : tb_h264_dc_hadamard
// Purpose  : Self-checking bench for h264_dc_hadamard: table of blocks with
//            expected results, scoreboard queue filled on drive and drained
//            by an output monitor, plus backpressure / gap / reset sequences.
// Revision : 1.0 - initial release
//----------------------------------------------------------------------------
`default_nettype none

module tb_h264_dc_hadamard;

  localparam int IW = 16;
  localparam int OW = 16;
  localparam int NV = 9;

  logic          CLK = 1'b0;
  logic          RESET, MODE, ENABLE, READYO;
  logic [IW-1:0] XXIN;
  logic          READYI, VALID, YYLAST;
  logic [OW-1:0] YYOUT;

  h264_dc_hadamard #(.IN_WIDTH(IW), .OUT_WIDTH(OW), .LUMA_EN(1'b1)) dut (
    .CLK(CLK), .RESET(RESET), .MODE(MODE), .ENABLE(ENABLE), .XXIN(XXIN),
    .READYI(READYI), .VALID(VALID), .YYOUT(YYOUT), .YYLAST(YYLAST),
    .READYO(READYO)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    bit mode;
    int din  [16];
    int dexp [16];
  } vec_t;

  typedef struct {
    int val;
    bit last;
  } exp_t;

  vec_t vecs [NV];
  exp_t sbq [$];
  int   n_vec = 0;
  int   n_err = 0;
  bit   mon_en = 1'b0;
  bit   ro_toggle = 1'b0;

  // Reference model: direct matrix products, not butterflies.
  function automatic int sat16(input longint v);
    if (v > 32767)  return 32767;
    if (v < -32768) return -32768;
    return int'(v);
  endfunction

  function automatic void model(input bit mode, input int x[16], output int y[16]);
    int h [4][4] = '{'{1, 1, 1, 1}, '{1, 1, -1, -1}, '{1, -1, -1, 1}, '{1, -1, 1, -1}};
    longint s;
    for (int i = 0; i < 16; i++) y[i] = 0;
    if (mode) begin
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++) begin
          s = 0;
          for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
              s += longint'(h[r][i] * h[c][j]) * longint'(x[4*i+j]);
          y[4*r+c] = sat16(s >>> 1);
        end
    end else begin
      y[0] = sat16(longint'(x[0]) + x[1] + x[2] + x[3]);
      y[1] = sat16(longint'(x[0]) - x[1] + x[2] - x[3]);
      y[2] = sat16(longint'(x[0]) + x[1] - x[2] - x[3]);
      y[3] = sat16(longint'(x[0]) - x[1] - x[2] + x[3]);
    end
  endfunction

  // READYO: held high, or toggled every cycle for backpressure.
  initial begin
    READYO = 1'b1;
    forever begin
      @(posedge CLK);
      #1;
      READYO = ro_toggle ? ~READYO : 1'b1;
    end
  end

  // Output monitor, sampled on the falling edge.
  initial begin
    bit held_v;
    int held_val;
    bit held_last;
    bit chk_after;
    exp_t e;
    held_v = 1'b0; held_val = 0; held_last = 1'b0; chk_after = 1'b0;
    forever begin
      @(negedge CLK);
      if (!mon_en) begin
        held_v = 1'b0;
        chk_after = 1'b0;
      end else begin
        if (chk_after) begin
          n_vec++;
          if (VALID !== 1'b0 || READYI !== 1'b1) begin
            n_err++;
            $display("FAIL after_last: VALID=%b READYI=%b, required VALID=0 READYI=1", VALID, READYI);
          end
          chk_after = 1'b0;
        end
        if (held_v && VALID) begin
          n_vec++;
          if (int'($signed(YYOUT)) != held_val || YYLAST !== held_last) begin
            n_err++;
            $display("FAIL hold_stable: YYOUT=%0d YYLAST=%b, required %0d/%b",
                     $signed(YYOUT), YYLAST, held_val, held_last);
          end
        end
        held_v = 1'b0;
        if (VALID) begin
          n_vec++;
          if (READYI !== 1'b0) begin
            n_err++;
            $display("FAIL readyi_busy: READYI=%b during output, required 0", READYI);
          end
          if (READYO) begin
            n_vec++;
            if (sbq.size() == 0) begin
              n_err++;
              $display("FAIL unexpected_out: YYOUT=%0d, required no output", $signed(YYOUT));
            end else begin
              e = sbq.pop_front();
              if (int'($signed(YYOUT)) != e.val || YYLAST !== e.last) begin
                n_err++;
                $display("FAIL out_coef: YYOUT=%0d YYLAST=%b, required %0d/%b",
                         $signed(YYOUT), YYLAST, e.val, e.last);
              end
              if (e.last) chk_after = 1'b1;
            end
          end else begin
            held_v    = 1'b1;
            held_val  = int'($signed(YYOUT));
            held_last = YYLAST;
          end
        end
      end
    end
  end

  task automatic send_coef(input int v, input logic m);
    int t;
    MODE   = m;
    XXIN   = IW'(v);
    ENABLE = 1'b1;
    t = 0;
    do begin
      @(negedge CLK);
      t++;
    end while (!READYI && t < 100);
    if (!READYI) begin
      n_vec++;
      n_err++;
      $display("FAIL send_timeout: READYI=%b, required 1", READYI);
    end
    @(posedge CLK);
    #1;
    ENABLE = 1'b0;
  endtask

  task automatic send_block(input bit mode, input int din[16], input bit gaps, input bit mtog);
    int n;
    n = mode ? 16 : 4;
    for (int i = 0; i < n; i++) begin
      if (gaps && (i % 2 == 1)) begin
        repeat (2) @(posedge CLK);
        #1;
      end
      send_coef(din[i], (mtog && i > 0) ? ~mode : mode);
    end
  endtask

  task automatic push_exp(input bit mode, input int dexp[16]);
    exp_t e;
    int n;
    n = mode ? 16 : 4;
    for (int i = 0; i < n; i++) begin
      e.val  = dexp[i];
      e.last = (i == n - 1);
      sbq.push_back(e);
    end
  endtask

  // Counts falling edges after the last input transfer until VALID.
  task automatic check_lat(input int want);
    int lat;
    lat = 0;
    do begin
      @(negedge CLK);
      lat++;
    end while (!VALID && lat < 40);
    n_vec++;
    if (lat != want) begin
      n_err++;
      $display("FAIL latency: %0d cycles, required %0d", lat, want);
    end
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (sbq.size() != 0 && t < 300) begin
      @(negedge CLK);
      t++;
    end
    n_vec++;
    if (sbq.size() != 0) begin
      n_err++;
      $display("FAIL drain_timeout: %0d outputs missing, required 0", sbq.size());
    end
    repeat (2) @(posedge CLK);
    #1;
  endtask

  task automatic check_reset_outs(input string nm);
    n_vec++;
    if (VALID !== 1'b0 || READYI !== 1'b1 || YYOUT !== '0 || YYLAST !== 1'b0) begin
      n_err++;
      $display("FAIL %s: VALID=%b READYI=%b YYOUT=%0d YYLAST=%b, required 0/1/0/0",
               nm, VALID, READYI, $signed(YYOUT), YYLAST);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int cin [4];
    // ---- vector table ----
    for (int v = 0; v < NV; v++) begin
      vecs[v].mode = 1'b0;
      for (int i = 0; i < 16; i++) begin
        vecs[v].din[i]  = 0;
        vecs[v].dexp[i] = 0;
      end
    end
    cin = '{1, 2, 3, 4};
    for (int i = 0; i < 4; i++) vecs[0].din[i] = cin[i];
    vecs[0].dexp[0] = 10; vecs[0].dexp[1] = -2; vecs[0].dexp[2] = -4; vecs[0].dexp[3] = 0;
    vecs[1].mode = 1'b1;
    for (int i = 0; i < 16; i++) vecs[1].din[i] = 1;
    vecs[1].dexp[0] = 8;
    vecs[2].mode = 1'b1;
    for (int i = 0; i < 16; i++) vecs[2].din[i] = 32767;
    vecs[2].dexp[0] = 32767;
    for (int i = 0; i < 4; i++) vecs[3].din[i] = -32768;
    vecs[3].dexp[0] = -32768;
    // Single -1 spreads to all entries; halving floors to -1.
    vecs[4].mode = 1'b1;
    vecs[4].din[0] = -1;
    for (int i = 0; i < 16; i++) vecs[4].dexp[i] = -1;
    vecs[5].mode = 1'b1;
    for (int i = 0; i < 16; i++) vecs[5].din[i] = int'($urandom_range(2000)) - 1000;
    model(1'b1, vecs[5].din, vecs[5].dexp);
    vecs[6].mode = 1'b1;
    for (int i = 0; i < 16; i++) vecs[6].din[i] = int'($urandom_range(65535)) - 32768;
    model(1'b1, vecs[6].din, vecs[6].dexp);
    for (int i = 0; i < 4; i++) vecs[7].din[i] = int'($urandom_range(65535)) - 32768;
    model(1'b0, vecs[7].din, vecs[7].dexp);
    cin = '{5, 6, 7, 8};
    for (int i = 0; i < 4; i++) vecs[8].din[i] = cin[i];
    vecs[8].dexp[0] = 26; vecs[8].dexp[1] = -2; vecs[8].dexp[2] = -4; vecs[8].dexp[3] = 0;

    // ---- reset ----
    RESET = 1'b1; ENABLE = 1'b0; MODE = 1'b0; XXIN = '0;
    repeat (3) @(posedge CLK);
    #1;
    check_reset_outs("reset_state");
    RESET = 1'b0;
    mon_en = 1'b1;
    @(posedge CLK);
    #1;

    // ---- table loop ----
    for (int v = 0; v < NV; v++) begin
      push_exp(vecs[v].mode, vecs[v].dexp);
      send_block(vecs[v].mode, vecs[v].din, 1'b0, 1'b0);
      check_lat(vecs[v].mode ? 9 : 3);
      drain();
    end

    // ---- backpressure ----
    ro_toggle = 1'b1;
    push_exp(1'b0, vecs[0].dexp);
    send_block(1'b0, vecs[0].din, 1'b0, 1'b0);
    check_lat(3);
    drain();
    ro_toggle = 1'b0;
    repeat (2) @(posedge CLK);
    #1;

    // ---- gaps + MODE toggling, ENABLE held during CALC/OUT ----
    push_exp(1'b1, vecs[5].dexp);
    send_block(1'b1, vecs[5].din, 1'b1, 1'b1);
    XXIN = 16'h7fff;
    ENABLE = 1'b1;
    check_lat(9);
    repeat (10) @(posedge CLK);
    #1;
    ENABLE = 1'b0;
    drain();
    push_exp(1'b0, vecs[7].dexp);
    send_block(1'b0, vecs[7].din, 1'b1, 1'b1);
    check_lat(3);
    drain();

    // ---- reset during CALC ----
    mon_en = 1'b0;
    send_block(1'b0, vecs[0].din, 1'b0, 1'b0);
    RESET = 1'b1;
    #1;
    check_reset_outs("reset_in_calc");
    #1;
    RESET = 1'b0;
    repeat (2) @(posedge CLK);
    #1;

    // ---- reset during OUT ----
    send_block(1'b1, vecs[1].din, 1'b0, 1'b0);
    begin
      int t;
      t = 0;
      do begin
        @(negedge CLK);
        t++;
      end while (!VALID && t < 40);
    end
    RESET = 1'b1;
    #1;
    check_reset_outs("reset_in_out");
    #1;
    RESET = 1'b0;
    sbq.delete();
    @(posedge CLK);
    #1;
    mon_en = 1'b1;
    push_exp(1'b0, vecs[8].dexp);
    send_block(1'b0, vecs[8].din, 1'b0, 1'b0);
    check_lat(3);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
